reflet_timer: RTL and testbench
===============================

# reflet_timer

Memory-mapped down-counting timer that sits on the reflet_cpu data bus beside the RAM and ROM and drives one bit of the CPU's `ext_int` input. The CPU programs a prescaler, a reload value and a control word through ordinary bus writes. The block counts down in prescaled ticks and raises a level interrupt on expiry. Read data is zero whenever the block is not selected, so the testbench or SoC can OR it onto the shared `data_in` bus.

## Interface
- `wordsize`, 16, width of the data bus and of all timer registers.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = held in reset, 1 = run).
- `enable`  in  1  chip select from the external address decode; bus access is ignored when 0.
- `addr`  in  2  register select: 0 CTRL, 1 PRESCALE, 2 RELOAD, 3 COUNT.
- `data_in`  in  `wordsize`  write data from the CPU `data_out`.
- `write_en`  in  1  write strobe; a write occurs when `enable & write_en`.
- `data_out`  out  `wordsize`  registered read data; zero when not selected.
- `irq`  out  1  interrupt request; connect to one `ext_int` bit.

## Operation
- CTRL bits:
  - [0] RUN.
  - [1] AUTORELOAD.
  - [2] IRQEN.
  - [3] PENDING. Writing 1 clears it; writing 0 leaves it unchanged.
  - Other bits read 0.
- PRESCALE, RELOAD and COUNT are full `wordsize` read/write registers.
- Reset clears every register, the prescaler counter, `data_out` and `irq` to 0.
- Prescaler:
  - Counts 0..PRESCALE while RUN=1, then issues a one-cycle tick and wraps to 0.
  - Tick period is PRESCALE+1 cycles. PRESCALE=0 ticks every cycle.
  - The prescaler is held at 0 while RUN=0.
  - A write to PRESCALE, or a 0→1 write of RUN, restarts the prescaler at 0.
- On a tick:
  - COUNT≠0: COUNT decrements by 1.
  - COUNT=0 (expiry): PENDING is set. If AUTORELOAD=1, COUNT loads RELOAD and RUN stays 1. If AUTORELOAD=0, COUNT stays 0 and RUN clears.
- Counter arithmetic is unsigned modulo 2^`wordsize`. No underflow past 0 ever occurs.
- `irq` = registered (PENDING & IRQEN). It stays high until software clears PENDING or IRQEN.
- Simultaneous events in the same cycle:
  - Expiry and a PENDING-clear write: set wins, PENDING stays 1.
  - A COUNT write and a tick: the write wins and the tick is consumed (no decrement).
  - A CTRL write with RUN=0 and an expiry: RUN ends at 0 and PENDING is set.
  - A RELOAD write and an auto-reload: COUNT loads the old RELOAD; the new RELOAD is used from the next reload.
- A write to an address with `enable`=0 has no effect.

## Timing
- Writes take effect at the rising edge on which `enable & write_en` is sampled high.
- Reads have 1-cycle latency:
  - `data_out` at cycle n+1 holds the register selected by `addr` at cycle n if `enable`=1 and `write_en`=0 at cycle n.
  - Otherwise `data_out` is 0 at cycle n+1.
  - Read values reflect register state before any same-edge update.
- `irq` rises exactly 1 cycle after the expiry edge and falls 1 cycle after the clearing write.
- Period between expiries with AUTORELOAD: (RELOAD+1)×(PRESCALE+1) cycles.
- Reset asserted mid-count returns the block to the reset state immediately, without waiting for `clk`. Counting resumes only after software sets RUN again.

## Structure
- Shared package `reflet_timer_pkg` holds:
  - register offsets (CTRL=0, PRESCALE=1, RELOAD=2, COUNT=3);
  - CTRL bit indices (RUN=0, AUTORELOAD=1, IRQEN=2, PENDING=3).
- One sub-module, `reflet_timer_prescaler`:
  - inputs: clk, reset, run, restart, limit[`wordsize`];
  - output: tick.
- Register file, down-counter, interrupt logic and read mux live in `reflet_timer`.

## Test plan
- Reset with reset=0 → all reads return 0, `irq`=0. Reads with `enable`=0 return 0 at any `addr`.
- PRESCALE=0, COUNT=3, CTRL=0x1 → COUNT reads 2,1,0 on successive cycles. On the next tick PENDING=1, RUN=0, COUNT stays 0, and `irq` stays 0 (IRQEN=0).
- PRESCALE=3, RELOAD=4, CTRL=0x7 → `irq` first rises (COUNT_initial+1)×4+1 cycles after RUN is set. Repeat expiries come every 20 cycles. Writing CTRL=0x0F drops `irq` one cycle later and leaves RUN=1.
- Force an expiry edge in the same cycle as a CTRL write of 0x0F → PENDING remains 1 and `irq` stays high.
- Write COUNT=0x00FF in the same cycle as a tick → COUNT reads 0x00FF, not 0x00FE. Write RELOAD in the same cycle as an auto-reload → the old value is loaded.
- Assert reset=0 while COUNT=0x0010 and RUN=1 → all outputs are 0 immediately. After reset=1, COUNT stays 0 with no ticks until RUN is written.

Source files
------------

// File: rtl/reflet_timer_pkg.sv
// Shared register map and CTRL bit layout for the reflet_timer bus peripheral.
package reflet_timer_pkg;

  localparam int WORDSIZE = 16;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_RELOAD   = 2'd2;
  localparam logic [1:0] ADDR_COUNT    = 2'd3;

  localparam int CTRL_RUN        = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_PENDING    = 3;

endpackage

// File: rtl/reflet_timer_prescaler.sv
// Prescaler: counts 0..limit while running and flags a tick on the last cycle of each period.
module reflet_timer_prescaler
  import reflet_timer_pkg::*;
#(
  parameter int wordsize = WORDSIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                restart,
  input  logic [wordsize-1:0] limit,
  output logic                tick
);

  logic [wordsize-1:0] cnt;
  logic                at_limit;

  assign at_limit = (cnt == limit);
  // A restart cancels the tick that would otherwise land on the same edge.
  assign tick     = run & ~restart & at_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || restart || at_limit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and level interrupt.
module reflet_timer
  import reflet_timer_pkg::*;
#(
  parameter int wordsize = WORDSIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);

  logic                run, autoreload, irqen, pending;
  logic [wordsize-1:0] prescale, reload, count;
  logic                wr, wr_ctrl, wr_pre, wr_rel, wr_cnt;
  logic                restart, tick, eff_tick, expire;
  logic [wordsize-1:0] ctrl_rd;

  assign wr      = enable & write_en;
  assign wr_ctrl = wr & (addr == ADDR_CTRL);
  assign wr_pre  = wr & (addr == ADDR_PRESCALE);
  assign wr_rel  = wr & (addr == ADDR_RELOAD);
  assign wr_cnt  = wr & (addr == ADDR_COUNT);

  assign restart  = wr_pre | (wr_ctrl & data_in[CTRL_RUN] & ~run);
  // A COUNT write on a tick edge swallows that tick entirely, expiry included.
  assign eff_tick = tick & ~wr_cnt;
  assign expire   = eff_tick & (count == '0);

  assign ctrl_rd = {{(wordsize-4){1'b0}}, pending, irqen, autoreload, run};

  reflet_timer_prescaler #(.wordsize(wordsize)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .restart (restart),
    .limit   (prescale),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run        <= 1'b0;
      autoreload <= 1'b0;
      irqen      <= 1'b0;
      pending    <= 1'b0;
      prescale   <= '0;
      reload     <= '0;
      count      <= '0;
    end else begin
      if (wr_ctrl) begin
        run        <= data_in[CTRL_RUN];
        autoreload <= data_in[CTRL_AUTORELOAD];
        irqen      <= data_in[CTRL_IRQEN];
      end else if (expire && !autoreload) begin
        run <= 1'b0;
      end

      // Expiry beats a same-edge clear so no interrupt is ever lost.
      pending <= (pending & ~(wr_ctrl & data_in[CTRL_PENDING])) | expire;

      if (wr_pre) prescale <= data_in;
      if (wr_rel) reload   <= data_in;

      if (wr_cnt) begin
        count <= data_in;
      end else if (eff_tick) begin
        if (count != '0)     count <= count - 1'b1;
        else if (autoreload) count <= reload;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      irq <= pending & irqen;
      if (enable && !write_en) begin
        case (addr)
          ADDR_CTRL:     data_out <= ctrl_rd;
          ADDR_PRESCALE: data_out <= prescale;
          ADDR_RELOAD:   data_out <= reload;
          default:       data_out <= count;
        endcase
      end else begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reflet_timer.sv
// Self-checking bench for reflet_timer: directed vector table, corner sequences, random run vs model.
module tb_reflet_timer;
  import reflet_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        write_en = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] data_in = 16'h0;
  logic [15:0] data_out;
  logic        irq;

  reflet_timer #(.wordsize(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: architectural register values plus the prescaler phase.
  bit          m_run, m_ar, m_ien, m_pend, m_irq;
  int          m_pre, m_rel, m_cnt, m_phase;
  logic [15:0] m_dout;

  typedef struct {
    bit          en;
    bit          we;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp_dout;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%04h expected 0x%04h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_ar = 0; m_ien = 0; m_pend = 0; m_irq = 0;
    m_pre = 0; m_rel = 0; m_cnt = 0; m_phase = 0; m_dout = 16'h0;
  endfunction

  function automatic logic [15:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {12'h0, m_pend, m_ien, m_ar, m_run};
      2'd1:    return 16'(m_pre);
      2'd2:    return 16'(m_rel);
      default: return 16'(m_cnt);
    endcase
  endfunction

  function automatic void model_edge(input bit en, input bit we, input logic [1:0] a,
                                     input logic [15:0] d);
    bit wr, rst_pre, tick, expire, old_ar;
    wr     = en && we;
    m_irq  = m_pend && m_ien;
    m_dout = (en && !we) ? m_reg(a) : 16'h0;
    rst_pre = wr && (a == 2'd1 || (a == 2'd0 && d[0] && !m_run));
    tick    = m_run && !rst_pre && (m_phase == m_pre);
    m_phase = (m_run && !rst_pre && !tick) ? m_phase + 1 : 0;
    if (wr && a == 2'd3) tick = 0;
    expire = tick && (m_cnt == 0);
    old_ar = m_ar;
    if (wr && a == 2'd3) m_cnt = int'(d);
    else if (tick) m_cnt = (m_cnt > 0) ? m_cnt - 1 : (old_ar ? m_rel : 0);
    if (wr && a == 2'd2) m_rel = int'(d);
    if (wr && a == 2'd1) m_pre = int'(d);
    if (wr && a == 2'd0) begin
      m_run = d[0]; m_ar = d[1]; m_ien = d[2];
      if (d[3]) m_pend = 0;
    end else if (expire && !old_ar) begin
      m_run = 0;
    end
    if (expire) m_pend = 1;
  endfunction

  task automatic cycle(input bit en, input bit we, input logic [1:0] a, input logic [15:0] d);
    enable = en; write_en = we; addr = a; data_in = d;
    @(posedge clk);
    model_edge(en, we, a, d);
    cyc++;
    @(negedge clk);
    chk("model_data_out", data_out, m_dout);
    chk("model_irq", {15'h0, irq}, {15'h0, m_irq});
  endtask

  function automatic void v(input bit en, input bit we, input logic [1:0] a,
                            input logic [15:0] d, input logic [15:0] ed, input bit ei);
    vec_t t;
    t.en = en; t.we = we; t.a = a; t.d = d; t.exp_dout = ed; t.exp_irq = ei;
    vecs.push_back(t);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, n;
    bit          r_en, r_we;
    logic [1:0]  r_a;
    logic [15:0] r_d;

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_data_out", data_out, 16'h0);
    chk("reset_irq", {15'h0, irq}, 16'h0);
    reset = 1'b1;

    // Reset reads, disabled access, PRESCALE=0 COUNT=3 one-shot run.
    v(1, 0, ADDR_CTRL,     0, 16'h0, 0);
    v(1, 0, ADDR_PRESCALE, 0, 16'h0, 0);
    v(1, 0, ADDR_RELOAD,   0, 16'h0, 0);
    v(1, 0, ADDR_COUNT,    0, 16'h0, 0);
    v(0, 0, ADDR_COUNT,    0, 16'h0, 0);
    v(0, 1, ADDR_COUNT, 16'hFFFF, 16'h0, 0);
    v(1, 0, ADDR_COUNT,    0, 16'h0, 0);
    v(1, 1, ADDR_PRESCALE, 16'h0, 16'h0, 0);
    v(1, 1, ADDR_COUNT,    16'h3, 16'h0, 0);
    v(1, 1, ADDR_CTRL,     16'h1, 16'h0, 0);
    v(1, 0, ADDR_COUNT,    0, 16'h3, 0);
    v(1, 0, ADDR_COUNT,    0, 16'h2, 0);
    v(1, 0, ADDR_COUNT,    0, 16'h1, 0);
    v(1, 0, ADDR_COUNT,    0, 16'h0, 0);
    v(1, 0, ADDR_COUNT,    0, 16'h0, 0);
    v(1, 0, ADDR_CTRL,     0, 16'h8, 0);
    v(1, 1, ADDR_CTRL,     16'h8, 16'h0, 0);
    v(1, 0, ADDR_CTRL,     0, 16'h0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {15'h0, irq}, {15'h0, vecs[i].exp_irq});
    end

    // Auto-reload: first irq, clear, repeat period, expiry vs clear collision.
    cycle(1, 1, ADDR_PRESCALE, 16'd3);
    cycle(1, 1, ADDR_RELOAD,   16'd4);
    cycle(1, 1, ADDR_COUNT,    16'd4);
    cycle(1, 1, ADDR_CTRL,     16'h7);
    t0 = cyc;
    for (n = 0; n < 100 && !irq; n++) cycle(0, 0, 2'd0, 16'h0);
    chk("irq_first_latency", 16'(cyc - t0), 16'd21);
    cycle(1, 1, ADDR_CTRL, 16'h0F);
    chk("irq_held_on_clear_edge", {15'h0, irq}, 16'h1);
    cycle(0, 0, 2'd0, 16'h0);
    chk("irq_dropped_after_clear", {15'h0, irq}, 16'h0);
    cycle(1, 0, ADDR_CTRL, 16'h0);
    chk("ctrl_after_clear", data_out, 16'h7);
    for (n = 0; n < 100 && !irq; n++) cycle(0, 0, 2'd0, 16'h0);
    chk("irq_second_latency", 16'(cyc - t0), 16'd41);
    cycle(1, 0, ADDR_CTRL, 16'h0);
    chk("ctrl_pending_again", data_out, 16'hF);
    while (cyc - t0 < 59) cycle(0, 0, 2'd0, 16'h0);
    cycle(1, 1, ADDR_CTRL, 16'h0F);
    cycle(0, 0, 2'd0, 16'h0);
    chk("irq_after_set_clear_collision", {15'h0, irq}, 16'h1);
    cycle(1, 0, ADDR_CTRL, 16'h0);
    chk("ctrl_after_set_clear_collision", data_out, 16'hF);
    chk("irq_still_high", {15'h0, irq}, 16'h1);

    // COUNT write on a tick edge, RELOAD write on an auto-reload edge.
    cycle(1, 1, ADDR_PRESCALE, 16'd0);
    cycle(1, 1, ADDR_CTRL, 16'h0B);
    cycle(1, 1, ADDR_COUNT, 16'h00FF);
    cycle(1, 0, ADDR_COUNT, 16'h0);
    chk("count_write_beats_tick", data_out, 16'h00FF);
    cycle(1, 0, ADDR_COUNT, 16'h0);
    chk("count_decrements_after", data_out, 16'h00FE);
    cycle(1, 1, ADDR_COUNT, 16'h0);
    cycle(1, 1, ADDR_RELOAD, 16'd9);
    cycle(1, 0, ADDR_COUNT, 16'h0);
    chk("reload_uses_old_value", data_out, 16'd4);
    cycle(1, 0, ADDR_RELOAD, 16'h0);
    chk("reload_holds_new_value", data_out, 16'd9);

    // Asynchronous reset mid-count.
    cycle(1, 1, ADDR_PRESCALE, 16'd5);
    cycle(1, 1, ADDR_COUNT, 16'h0010);
    cycle(1, 1, ADDR_CTRL, 16'h7);
    cycle(1, 0, ADDR_COUNT, 16'h0);
    chk("count_before_reset", data_out, 16'h0010);
    chk("irq_before_reset", {15'h0, irq}, 16'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_data_out", data_out, 16'h0);
    chk("async_reset_irq", {15'h0, irq}, 16'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (10) cycle(0, 0, 2'd0, 16'h0);
    cycle(1, 0, ADDR_COUNT, 16'h0);
    chk("count_after_reset", data_out, 16'h0);
    cycle(1, 0, ADDR_CTRL, 16'h0);
    chk("ctrl_after_reset", data_out, 16'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r_en = ($urandom_range(0, 9) != 0);
      r_we = ($urandom_range(0, 3) == 0);
      r_a  = 2'($urandom_range(0, 3));
      case (r_a)
        2'd0:    r_d = 16'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 16'h1 : 16'h0);
        2'd1:    r_d = 16'($urandom_range(0, 3));
        default: r_d = 16'($urandom_range(0, 6));
      endcase
      cycle(r_en, r_we, r_a, r_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
